// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg : shared types and constants for the MIPS pipeline front end
// Rev 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam int          WORD_W   = 32;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  typedef struct packed {
    logic [WORD_W-1:0] pc_add;
    logic [WORD_W-1:0] instr;
    logic              valid;
  } ifid_t;

endpackage

`default_nettype wire

// File: rtl/if_id_latch.sv
// ============================================================================
// if_id_latch : 65-bit IF/ID register {PCAddResult, Instruction, Valid}
// Rev 1.0
// ============================================================================
`default_nettype none

module if_id_latch
  import pipeline_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP = NOP_WORD
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_load,
  input  logic  i_flush,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;

  // Flush wins over load; a bubble keeps the old PC+4 but is never valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q.pc_add <= '0;
      r_q.instr  <= NOP;
      r_q.valid  <= 1'b0;
    end else if (i_flush) begin
      r_q.instr  <= NOP;
      r_q.valid  <= 1'b0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : stallable, flushable instruction-fetch stage (PC, FSM, IF/ID)
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = pipeline_pkg::NOP_WORD
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [WORD_W-1:0] BranchTarget,
  output logic              IMemReq,
  output logic [WORD_W-1:0] IMemAddr,
  input  logic [WORD_W-1:0] IMemData,
  input  logic              IMemReady,
  output logic [WORD_W-1:0] PCAddResultOut,
  output logic [WORD_W-1:0] InstructionOut,
  output logic              ValidOut
);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [WORD_W-1:0] r_pc;
  ifid_t             r_hold;

  logic [WORD_W-1:0] w_pc4;
  logic [WORD_W-1:0] w_target;
  logic              w_redirect;
  logic              w_ifid_load;
  logic              w_ifid_flush;
  ifid_t             w_ifid_d;
  ifid_t             w_ifid_q;
  logic              w_hold_wr;
  logic              w_pc_inc;

  assign w_pc4      = r_pc + PC_STEP;
  assign w_target   = BranchTarget & ~32'h3;
  assign w_redirect = BranchTaken && (r_state != S_IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_FETCH;
      S_FETCH: begin
        if (w_redirect)              w_next_state = S_FETCH;
        else if (IMemReady && Stall) w_next_state = S_HOLD;
      end
      S_HOLD: begin
        if (w_redirect || !Stall) w_next_state = S_FETCH;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    IMemReq      = 1'b0;
    w_ifid_load  = 1'b0;
    w_ifid_flush = 1'b0;
    w_ifid_d     = '{pc_add: w_pc4, instr: IMemData, valid: 1'b1};
    w_hold_wr    = 1'b0;
    w_pc_inc     = 1'b0;
    case (r_state)
      S_FETCH: begin
        IMemReq = 1'b1;
        if (IMemReady) begin
          w_pc_inc    = 1'b1;
          w_ifid_load = !Stall;
          w_hold_wr   = Stall;
        end else begin
          w_ifid_flush = !Stall;
        end
      end
      S_HOLD: begin
        w_ifid_d    = r_hold;
        w_ifid_load = !Stall;
      end
      default: ;
    endcase
    // A redirect overrides whatever the fetch would have done this cycle.
    if (w_redirect) begin
      w_ifid_load  = 1'b0;
      w_ifid_flush = 1'b1;
      w_hold_wr    = 1'b0;
      w_pc_inc     = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc   <= RESET_PC;
      r_hold <= '0;
    end else begin
      if (w_redirect)    r_pc <= w_target;
      else if (w_pc_inc) r_pc <= w_pc4;

      if (w_redirect)     r_hold.valid <= 1'b0;
      else if (w_hold_wr) r_hold <= '{pc_add: w_pc4, instr: IMemData, valid: 1'b1};
    end
  end

  if_id_latch #(
    .NOP (NOP_WORD)
  ) u_if_id (
    .clk     (Clk),
    .rst_n   (Reset),
    .i_load  (w_ifid_load),
    .i_flush (w_ifid_flush),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign IMemAddr       = r_pc;
  assign PCAddResultOut = w_ifid_q.pc_add;
  assign InstructionOut = w_ifid_q.instr;
  assign ValidOut       = w_ifid_q.valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : directed self-checking bench for fetch_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic        IMemReady = 1'b0;
  logic [31:0] PCAddResultOut;
  logic [31:0] InstructionOut;
  logic        ValidOut;

  logic        auto_mem = 1'b0;
  logic [31:0] data_drv = 32'h0;
  int          passed = 0;
  int          total  = 0;

  // Auto mode: memory returns addr + 0x1000 for any address.
  assign IMemData = auto_mem ? (IMemAddr + 32'h1000) : data_drv;

  always #5 Clk = ~Clk;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Stall          (Stall),
    .BranchTaken    (BranchTaken),
    .BranchTarget   (BranchTarget),
    .IMemReq        (IMemReq),
    .IMemAddr       (IMemAddr),
    .IMemData       (IMemData),
    .IMemReady      (IMemReady),
    .PCAddResultOut (PCAddResultOut),
    .InstructionOut (InstructionOut),
    .ValidOut       (ValidOut)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Leaves the DUT in FETCH with PC = 0.
  task automatic do_reset();
    Reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; IMemReady = 1'b0;
    #2;
    @(negedge Clk);
    Reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #2;
    total++; if (ValidOut !== 1'b0) $display("FAIL reset_valid: got %b want 0", ValidOut); else passed++;
    total++; if (InstructionOut !== 32'h0) $display("FAIL reset_instr: got %h want 00000000", InstructionOut); else passed++;
    total++; if (PCAddResultOut !== 32'h0) $display("FAIL reset_pc4: got %h want 00000000", PCAddResultOut); else passed++;
    total++; if (IMemReq !== 1'b0) $display("FAIL reset_req: got %b want 0", IMemReq); else passed++;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    total++; if (IMemReq !== 1'b0) $display("FAIL idle_req: got %b want 0", IMemReq); else passed++;
    step();
    total++; if (IMemReq !== 1'b1) $display("FAIL first_req: got %b want 1", IMemReq); else passed++;
    total++; if (IMemAddr !== 32'h0) $display("FAIL first_addr: got %h want 00000000", IMemAddr); else passed++;
  endtask

  task automatic test_sequential();
    auto_mem = 1'b1; IMemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (IMemAddr !== 32'(4*i)) $display("FAIL seq_addr[%0d]: got %h want %h", i, IMemAddr, 32'(4*i)); else passed++;
      step();
      total++; if (InstructionOut !== 32'(32'h1000 + 4*i)) $display("FAIL seq_instr[%0d]: got %h want %h", i, InstructionOut, 32'(32'h1000 + 4*i)); else passed++;
      total++; if (PCAddResultOut !== 32'(4*i + 4)) $display("FAIL seq_pc4[%0d]: got %h want %h", i, PCAddResultOut, 32'(4*i + 4)); else passed++;
      total++; if (ValidOut !== 1'b1) $display("FAIL seq_valid[%0d]: got %b want 1", i, ValidOut); else passed++;
    end
  endtask

  task automatic test_not_ready();
    do_reset();
    auto_mem = 1'b1; IMemReady = 1'b1;
    step(); step();
    IMemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (IMemAddr !== 32'h8) $display("FAIL wait_addr[%0d]: got %h want 00000008", i, IMemAddr); else passed++;
      total++; if (ValidOut !== 1'b0) $display("FAIL wait_valid[%0d]: got %b want 0", i, ValidOut); else passed++;
    end
    IMemReady = 1'b1;
    step();
    total++; if (PCAddResultOut !== 32'hC) $display("FAIL wait_pc4: got %h want 0000000c", PCAddResultOut); else passed++;
    total++; if (InstructionOut !== 32'h1008) $display("FAIL wait_instr: got %h want 00001008", InstructionOut); else passed++;
    total++; if (ValidOut !== 1'b1) $display("FAIL wait_valid_end: got %b want 1", ValidOut); else passed++;
  endtask

  task automatic test_stall_hold();
    do_reset();
    auto_mem = 1'b0; IMemReady = 1'b1; data_drv = 32'hAAAA_0000;
    step();
    Stall = 1'b1; data_drv = 32'hAAAA_0004;
    step();
    total++; if (InstructionOut !== 32'hAAAA_0000) $display("FAIL hold_keep_instr: got %h want aaaa0000", InstructionOut); else passed++;
    total++; if (PCAddResultOut !== 32'h4) $display("FAIL hold_keep_pc4: got %h want 00000004", PCAddResultOut); else passed++;
    total++; if (IMemReq !== 1'b0) $display("FAIL hold_req: got %b want 0", IMemReq); else passed++;
    data_drv = 32'hDEAD_BEEF;
    step();
    total++; if (InstructionOut !== 32'hAAAA_0000) $display("FAIL hold_stable: got %h want aaaa0000", InstructionOut); else passed++;
    total++; if (IMemReq !== 1'b0) $display("FAIL hold_req2: got %b want 0", IMemReq); else passed++;
    Stall = 1'b0; IMemReady = 1'b0;
    step();
    total++; if (InstructionOut !== 32'hAAAA_0004) $display("FAIL release_instr: got %h want aaaa0004", InstructionOut); else passed++;
    total++; if (PCAddResultOut !== 32'h8) $display("FAIL release_pc4: got %h want 00000008", PCAddResultOut); else passed++;
    total++; if (ValidOut !== 1'b1) $display("FAIL release_valid: got %b want 1", ValidOut); else passed++;
    total++; if (IMemAddr !== 32'h8 || IMemReq !== 1'b1) $display("FAIL release_addr: got %h/%b want 00000008/1", IMemAddr, IMemReq); else passed++;
  endtask

  task automatic test_branch_flush();
    do_reset();
    auto_mem = 1'b0; IMemReady = 1'b1; data_drv = 32'hBBBB_0000;
    step();
    Stall = 1'b1; data_drv = 32'hBBBB_0004;
    step();
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0043;
    step();
    total++; if (ValidOut !== 1'b0) $display("FAIL br_valid: got %b want 0", ValidOut); else passed++;
    total++; if (InstructionOut !== 32'h0) $display("FAIL br_instr: got %h want 00000000", InstructionOut); else passed++;
    total++; if (IMemAddr !== 32'h40) $display("FAIL br_addr: got %h want 00000040", IMemAddr); else passed++;
    total++; if (IMemReq !== 1'b1) $display("FAIL br_req: got %b want 1", IMemReq); else passed++;
    BranchTaken = 1'b0; Stall = 1'b0; data_drv = 32'hCCCC_0040;
    step();
    total++; if (InstructionOut !== 32'hCCCC_0040) $display("FAIL br_next_instr: got %h want cccc0040", InstructionOut); else passed++;
    total++; if (PCAddResultOut !== 32'h44) $display("FAIL br_next_pc4: got %h want 00000044", PCAddResultOut); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    auto_mem = 1'b1; IMemReady = 1'b1;
    for (int i = 0; i < 8; i++) step();
    total++; if (IMemAddr !== 32'h20) $display("FAIL mid_pre_addr: got %h want 00000020", IMemAddr); else passed++;
    #2;
    Reset = 1'b0;
    #1;
    total++; if (ValidOut !== 1'b0) $display("FAIL mid_valid: got %b want 0", ValidOut); else passed++;
    total++; if (InstructionOut !== 32'h0) $display("FAIL mid_instr: got %h want 00000000", InstructionOut); else passed++;
    total++; if (IMemReq !== 1'b0) $display("FAIL mid_req: got %b want 0", IMemReq); else passed++;
    @(negedge Clk);
    Reset = 1'b1;
    step();
    total++; if (IMemAddr !== 32'h0 || IMemReq !== 1'b1) $display("FAIL mid_restart: got %h/%b want 00000000/1", IMemAddr, IMemReq); else passed++;
  endtask

  task automatic test_wrap();
    auto_mem = 1'b0; IMemReady = 1'b0;
    BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    step();
    total++; if (IMemAddr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h want fffffffc", IMemAddr); else passed++;
    BranchTaken = 1'b0; IMemReady = 1'b1; data_drv = 32'hDDDD_0000;
    step();
    total++; if (PCAddResultOut !== 32'h0) $display("FAIL wrap_pc4: got %h want 00000000", PCAddResultOut); else passed++;
    total++; if (InstructionOut !== 32'hDDDD_0000) $display("FAIL wrap_instr: got %h want dddd0000", InstructionOut); else passed++;
    total++; if (IMemAddr !== 32'h0) $display("FAIL wrap_next_addr: got %h want 00000000", IMemAddr); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_not_ready();
    test_stall_hold();
    test_branch_flush();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, issues requests to instruction memory with a ready handshake, computes PC+4 and holds the IF/ID pipeline outputs consumed by decode.
- Honours Stall from the hazard unit and redirects and flushes on a taken branch resolved downstream (PCSrc).
- Replaces the open-loop PCAdder-to-IF/ID path with a stallable, flushable front end.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word driven into IF/ID on flush or bubble (sll $0,$0,0).

Ports:
- Clk  in  1  pipeline clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hazard unit: hold PC and IF/ID contents.
- BranchTaken  in  1  taken branch/jump resolved downstream; redirect PC.
- BranchTarget  in  32  redirect address, word aligned.
- IMemReq  out  1  fetch request valid.
- IMemAddr  out  32  fetch address (= PC).
- IMemData  in  32  instruction word, valid when IMemReady=1.
- IMemReady  in  1  memory returns IMemData this cycle; may be same cycle as request.
- PCAddResultOut  out  32  IF/ID: PC+4 of held instruction.
- InstructionOut  out  32  IF/ID: held instruction.
- ValidOut  out  1  IF/ID: instruction is real (0 = bubble).

Behaviour:
- Reset (async, Reset=0):
  - PC=RESET_PC; state=IDLE; IMemReq=0.
  - InstructionOut=NOP_WORD; PCAddResultOut=0; ValidOut=0; hold register cleared.
- States: IDLE, FETCH, HOLD.
- IDLE:
  - One cycle after Reset deasserts, so that the first request is synchronous.
  - Next state FETCH.
- FETCH:
  - IMemReq=1; IMemAddr=PC.
  - IMemReady=1 and Stall=0: IF/ID <= {PC+4, IMemData, valid=1}; PC <= PC+4; stay in FETCH.
  - IMemReady=1 and Stall=1: IF/ID unchanged; word and PC+4 go to the hold register; PC <= PC+4; go to HOLD.
  - IMemReady=0 and Stall=0: IF/ID <= bubble (NOP_WORD, ValidOut=0); PC unchanged.
  - IMemReady=0 and Stall=1: IF/ID unchanged.
- HOLD:
  - IMemReq=0.
  - Stall=1: everything unchanged.
  - Stall=0: IF/ID <= hold register with valid=1; go to FETCH.
- BranchTaken=1 (highest priority, any state except IDLE):
  - PC <= BranchTarget.
  - IF/ID <= bubble (NOP_WORD, ValidOut=0), regardless of Stall.
  - Hold register invalidated; a same-cycle IMemReady word is discarded.
  - Next state FETCH.
  - IMemReq may still be high that cycle; the returned data is ignored.
- Latency: best case one instruction per cycle. Request in cycle N with IMemReady in N puts the word on InstructionOut from N+1.
- Arithmetic:
  - PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no flag.
  - PC[1:0] always 0. BranchTarget[1:0] is ignored and forced to 0.
- Stall held indefinitely: outputs stable, at most one word buffered, no further requests.
- Reset mid-operation: asynchronous clear per the reset values; a pending memory response is ignored.

Decomposition:
- Shared package pipeline_pkg:
  - state encoding (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2)
  - NOP_WORD constant
  - WORD_W=32
  - PC_STEP=4
- One natural sub-module, if_id_latch: 65-bit register {PCAddResult, Instruction, Valid} with load, flush and async active-low clear. Also reused by the decode team.
- PC register and FSM stay in fetch_stage.

Test Plan:
- Reset, then IMemReady tied 1 with IMemData=addr+32'h1000: IMemAddr sequence 0,4,8,C; InstructionOut 32'h1000,32'h1004… from the 2nd fetch cycle; ValidOut=1.
- IMemReady=0 for 3 cycles at PC=8: IMemAddr holds 8; ValidOut=0 for 3 cycles; PCAddResultOut=C once ready.
- Stall=1 in the cycle word 32'hAAAA_0004 arrives: IF/ID keeps the prior word; state HOLD; IMemReq=0. Stall=0: InstructionOut=32'hAAAA_0004, PCAddResultOut=8; next IMemAddr=8.
- BranchTaken=1, BranchTarget=32'h0000_0040, with Stall=1 and a word held: next cycle ValidOut=0, InstructionOut=0, IMemAddr=40; the held word is never emitted.
- Reset dropped mid-FETCH at PC=0x20: outputs clear immediately (asynchronously); after release IMemAddr=RESET_PC.
- PC=32'hFFFF_FFFC with ready: PCAddResultOut=0; next IMemAddr=0.
